// File: rtl/calc_scan.sv
// +--------------------------------------------------------------------------+
// | calc_scan : four-function decimal keypad calculator with a scanned       |
// |             one-digit-per-cycle display output.                          |
// | Rev 1.0   : initial release                                              |
// +--------------------------------------------------------------------------+
`default_nettype none

module calc_scan #(
  parameter int NDIG  = 8,
  parameter int WIDTH = 27
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic [3:0] cmd_i,
  input  logic       cmd_valid_i,
  output logic [1:0] status_o,
  output logic [3:0] data_o,
  output logic [3:0] pos_o
);

  localparam int CW = $clog2(NDIG + 1);
  localparam int SW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int KW = $clog2(WIDTH);
  localparam int BW = 4 * NDIG;
  localparam int PW = 2 * WIDTH;

  function automatic logic [63:0] pow10m1(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p - 64'd1;
  endfunction

  localparam logic [PW-1:0] MAXP = PW'(pow10m1(NDIG));
  localparam logic [WIDTH:0] MAXS = (WIDTH + 1)'(pow10m1(NDIG));

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;

  typedef enum logic [2:0] {
    WAIT_A = 3'd0,
    WAIT_B = 3'd1,
    MULT   = 3'd2,
    CONV   = 3'd3,
    RESULT = 3'd4,
    ERROR  = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [BW-1:0]      bcd_q, bcd_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   rega_q, rega_d;
  logic [WIDTH-1:0]   regb_q, regb_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [BW-1:0]      dd_q, dd_d;
  logic [PW-1:0]      mcand_q, mcand_d;
  logic [PW-1:0]      prod_q, prod_d;
  logic [KW-1:0]      cyc_q, cyc_d;
  logic [SW-1:0]      scan_q, scan_d;
  logic [1:0]         status_q, status_d;
  logic [3:0]         data_q, data_d;
  logic [3:0]         pos_q;

  logic               w_dig, w_op, w_eq, w_bs, w_clr;
  logic [1:0]         w_opc;
  logic [WIDTH:0]     w_sum;
  logic [PW-1:0]      w_prod_nx;
  logic [BW-1:0]      w_adj;
  logic [BW-1:0]      w_src;
  logic [NDIG-1:0]    w_nzup;
  logic               w_acc;

  assign w_dig = cmd_valid_i && (cmd_i <= 4'd9);
  assign w_op  = cmd_valid_i && (cmd_i >= 4'hA) && (cmd_i <= 4'hC);
  assign w_eq  = cmd_valid_i && (cmd_i == 4'hD);
  assign w_bs  = cmd_valid_i && (cmd_i == 4'hE);
  assign w_clr = cmd_valid_i && (cmd_i == 4'hF);

  always_comb begin
    case (cmd_i)
      4'hA:    w_opc = OP_ADD;
      4'hB:    w_opc = OP_SUB;
      default: w_opc = OP_MUL;
    endcase
  end

  assign w_sum     = {1'b0, rega_q} + {1'b0, opnd_q};
  assign w_prod_nx = prod_q + (regb_q[0] ? mcand_q : '0);

  // Double-dabble correction: every BCD digit >= 5 gets +3 before the shift.
  always_comb begin
    w_adj = dd_q;
    for (int k = 0; k < NDIG; k++) begin
      if (dd_q[4*k +: 4] >= 4'd5) w_adj[4*k +: 4] = dd_q[4*k +: 4] + 4'd3;
    end
  end

  assign w_src = (state_q == RESULT) ? dd_q : bcd_q;

  always_comb begin
    w_nzup = '0;
    w_acc  = 1'b0;
    for (int k = NDIG - 1; k >= 0; k--) begin
      w_acc     = w_acc | (w_src[4*k +: 4] != 4'd0);
      w_nzup[k] = w_acc;
    end
  end

  function automatic logic [1:0] status_of(input state_t s);
    case (s)
      WAIT_A, WAIT_B: return 2'b00;
      MULT, CONV:     return 2'b01;
      ERROR:          return 2'b10;
      default:        return 2'b11;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    opnd_d  = opnd_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    rega_d  = rega_q;
    regb_d  = regb_q;
    op_d    = op_q;
    res_d   = res_q;
    dd_d    = dd_q;
    mcand_d = mcand_q;
    prod_d  = prod_q;
    cyc_d   = cyc_q;

    case (state_q)
      WAIT_A, WAIT_B: begin
        if (w_dig) begin
          if (cnt_q < CW'(NDIG)) begin
            opnd_d = opnd_q * WIDTH'(10) + WIDTH'(cmd_i);
            bcd_d  = {bcd_q[BW-5:0], cmd_i};
            cnt_d  = cnt_q + CW'(1);
          end
        end else if (w_bs) begin
          if (cnt_q != '0) begin
            opnd_d = opnd_q / WIDTH'(10);
            bcd_d  = {4'h0, bcd_q[BW-1:4]};
            cnt_d  = cnt_q - CW'(1);
          end
        end else if (w_op) begin
          if (state_q == WAIT_A) begin
            rega_d  = opnd_q;
            op_d    = w_opc;
            opnd_d  = '0;
            bcd_d   = '0;
            cnt_d   = '0;
            state_d = WAIT_B;
          end else if (cnt_q == '0) begin
            op_d = w_opc;
          end
        end else if (w_eq && state_q == WAIT_B) begin
          regb_d = opnd_q;
          dd_d   = '0;
          cyc_d  = '0;
          case (op_q)
            OP_ADD: begin
              if (w_sum > MAXS) state_d = ERROR;
              else begin
                res_d   = w_sum[WIDTH-1:0];
                state_d = CONV;
              end
            end
            OP_SUB: begin
              if (opnd_q > rega_q) state_d = ERROR;
              else begin
                res_d   = rega_q - opnd_q;
                state_d = CONV;
              end
            end
            default: begin
              mcand_d = {{WIDTH{1'b0}}, rega_q};
              prod_d  = '0;
              state_d = MULT;
            end
          endcase
        end
      end

      MULT: begin
        prod_d  = w_prod_nx;
        mcand_d = mcand_q << 1;
        regb_d  = regb_q >> 1;
        cyc_d   = cyc_q + KW'(1);
        if (cyc_q == KW'(WIDTH - 1)) begin
          cyc_d = '0;
          dd_d  = '0;
          if (w_prod_nx > MAXP) state_d = ERROR;
          else begin
            res_d   = w_prod_nx[WIDTH-1:0];
            state_d = CONV;
          end
        end
      end

      // res_q is rotated rather than shifted so it is intact after WIDTH steps.
      CONV: begin
        res_d = {res_q[WIDTH-2:0], res_q[WIDTH-1]};
        dd_d  = {w_adj[BW-2:0], res_q[WIDTH-1]};
        cyc_d = cyc_q + KW'(1);
        if (cyc_q == KW'(WIDTH - 1)) begin
          cyc_d   = '0;
          state_d = RESULT;
        end
      end

      RESULT: begin
        if (w_dig) begin
          opnd_d  = WIDTH'(cmd_i);
          bcd_d   = BW'(cmd_i);
          cnt_d   = CW'(1);
          state_d = WAIT_A;
        end else if (w_op) begin
          rega_d  = res_q;
          op_d    = w_opc;
          opnd_d  = '0;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = WAIT_B;
        end
      end

      default: ;
    endcase

    if (w_clr) begin
      state_d = WAIT_A;
      opnd_d  = '0;
      bcd_d   = '0;
      cnt_d   = '0;
      rega_d  = '0;
      regb_d  = '0;
      op_d    = OP_ADD;
      res_d   = '0;
      dd_d    = '0;
      mcand_d = '0;
      prod_d  = '0;
      cyc_d   = '0;
    end
  end

  assign status_d = status_of(state_d);
  assign scan_d   = (scan_q == SW'(NDIG - 1)) ? '0 : scan_q + SW'(1);

  always_comb begin
    data_d = w_src[4*int'(scan_q) +: 4];
    if (state_q == ERROR) data_d = 4'hE;
    else if (scan_q != '0 && !w_nzup[scan_q]) data_d = 4'hF;
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= WAIT_A;
      opnd_q   <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      rega_q   <= '0;
      regb_q   <= '0;
      op_q     <= OP_ADD;
      res_q    <= '0;
      dd_q     <= '0;
      mcand_q  <= '0;
      prod_q   <= '0;
      cyc_q    <= '0;
      scan_q   <= '0;
      status_q <= 2'b00;
      data_q   <= 4'h0;
      pos_q    <= 4'h0;
    end else begin
      state_q  <= state_d;
      opnd_q   <= opnd_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      rega_q   <= rega_d;
      regb_q   <= regb_d;
      op_q     <= op_d;
      res_q    <= res_d;
      dd_q     <= dd_d;
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      cyc_q    <= cyc_d;
      scan_q   <= scan_d;
      status_q <= status_d;
      data_q   <= data_d;
      pos_q    <= 4'(scan_q);
    end
  end

  assign status_o = status_q;
  assign data_o   = data_q;
  assign pos_o    = pos_q;

endmodule

`default_nettype wire

// File: doc/calc_scan.md
CALC_SCAN -- requirements
Module: calc_scan

Interface
REQ-001 Parameter NDIG, default 8, number of decimal display digits (legal range 2..16).
REQ-002 Parameter WIDTH, default 27, binary operand/result width; SHALL satisfy 10^NDIG-1 < 2^WIDTH.
REQ-003 clock  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 cmd  input  4  key code: 0-9 digit, A add, B subtract, C multiply, D equals, E backspace, F clear.
REQ-006 cmd_valid  input  1  one-cycle strobe; cmd SHALL be acted on only in cycles where cmd_valid=1.
REQ-007 status  output  2  00 entering, 01 busy, 10 error, 11 result shown.
REQ-008 data  output  4  displayed digit value at position pos (0-9), F = blank, E = error glyph.
REQ-009 pos  output  4  display position being driven, 0 = least-significant digit.

Function
REQ-010 States SHALL be WAIT_A, WAIT_B, MULT, CONV, RESULT, ERROR.
REQ-011 WAIT_A/WAIT_B SHALL keep both a binary operand and a per-digit BCD image; a digit key SHALL update operand = operand*10+cmd and shift BCD left one digit.
REQ-012 A digit key SHALL be ignored once NDIG digits are entered in the current operand.
REQ-013 Backspace SHALL set operand = operand/10, shift BCD right, and decrement the digit count; with count 0 it SHALL have no effect.
REQ-014 Operator key (A/B/C) in WAIT_A SHALL latch regA and op, clear the entry, and go to WAIT_B.
REQ-015 Operator key in WAIT_B with zero digits entered SHALL replace the stored op; with digits entered it SHALL be ignored.
REQ-016 Equals in WAIT_A SHALL be ignored; equals in WAIT_B SHALL latch regB (0 if no digits).
REQ-017 On equals with op add/sub, the result SHALL be computed on the same edge and the FSM SHALL enter CONV.
REQ-018 On equals with op multiply, the FSM SHALL enter MULT and run shift-and-add, one regB bit per cycle, for exactly WIDTH cycles, then enter CONV.
REQ-019 A subtract result below 0 SHALL go to ERROR instead of CONV.
REQ-020 A result above 10^NDIG-1, including multiply overflow of WIDTH bits, SHALL go to ERROR instead of CONV.
REQ-021 CONV SHALL convert the binary result to BCD by double-dabble in exactly WIDTH cycles, then enter RESULT.
REQ-022 In MULT and CONV, status SHALL be 01, and every cmd except F SHALL be ignored.
REQ-023 In RESULT, a digit key SHALL start a new regA entry holding that digit, going to WAIT_A.
REQ-024 In RESULT, an operator key SHALL load regA with the result, latch op, and go to WAIT_B.
REQ-025 In RESULT, equals and backspace SHALL be ignored.
REQ-026 In ERROR, status SHALL be 10 and only F SHALL be accepted.
REQ-027 Clear (F) in any state SHALL zero all operands, BCD images and counts, and go to WAIT_A on the next edge.
REQ-028 The scan index SHALL advance 0,1,...,NDIG-1,0 every cycle unconditionally; pos and data SHALL be registered, updating together on the same edge.
REQ-029 The displayed value SHALL be the current entry (WAIT_A/WAIT_B), the last shown entry (MULT/CONV), or the result (RESULT).
REQ-030 Leading zeros above the most-significant nonzero digit SHALL show F; position 0 SHALL always show a digit, so an empty entry shows 0.
REQ-031 In ERROR, data SHALL be E at every position.

Reset
REQ-032 Reset SHALL force WAIT_A, zero all operands, BCD images, counters and op, set scan index 0, status=00, data=0, pos=0.
REQ-033 Reset asserted mid-MULT or mid-CONV SHALL abort the operation with no residual result.

Verification
REQ-034 Keys 1,2,A,3,4,D (NDIG=8) -> status 01 for WIDTH cycles, then 11; display shows data 6 at pos 0, 4 at pos 1, F at pos 2..7.
REQ-035 Keys 5,B,9,D -> status 10 one cycle after D; all positions show E; key F -> status 00, pos 0 shows 0.
REQ-036 Keys 9999,C,9999,D -> status 01 for 2*WIDTH cycles, then 11 showing 99980001; then 9,9,9,9,9,9,9,9,C,2,D -> status 10.
REQ-037 Keys 1,2,3,E,E,4 -> entry shows 14; 9 further digit keys -> only 6 accepted, shows 14999999.
REQ-038 Reset pulsed 5 cycles into MULT -> status 00, data 0, pos 0 next cycle; scan restarts at pos 0.
REQ-039 Key 7 with cmd_valid=0 held 10 cycles -> no change to entry; result 46 then key A,4,D -> shows 50.
